serial_deserializer: RTL and testbench
======================================

Name: serial_deserializer

Overview:
Receive-side counterpart of the team's 4-bit shift-capable register used as a serializer (shift-right, LSB-first out of bit 0). Samples a qualified serial bitstream, reassembles WIDTH-bit words, and presents them on a valid/ready word interface through a one-entry output buffer. Sits between the serial link and the consuming datapath/register file.

Parameters:
WIDTH, 4, data bits per frame (legal: 1 to 32).
LSB_FIRST, 1, 1 = first received bit lands in out_data[0]; 0 = first bit lands in out_data[WIDTH-1].

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  reset; synchronous, active-high.
ser_valid  input  1  ser_data/ser_start are sampled only when this is 1.
ser_data  input  1  serial data bit.
ser_start  input  1  qualified with ser_valid; marks the first data bit of a frame.
out_valid  output  1  out_data holds a complete word.
out_ready  input  1  consumer accepts the word when out_valid && out_ready.
out_data  output  WIDTH  assembled word; stable while out_valid && !out_ready.
frame_err  output  1  one-cycle pulse on frame restart or a stray bit.
overrun  output  1  sticky; set when a completed word is dropped.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE, bit count 0, shift register 0, out_valid 0, out_data 0, frame_err 0, overrun 0. Reset mid-frame discards the partial word; reset while out_valid=1 discards the buffered word.
- States: IDLE, SHIFT (plus PARITY under the optional feature).
- IDLE:
  - ser_valid && ser_start: capture the bit as bit 0, count=1, go to SHIFT. If WIDTH=1, complete immediately instead.
  - ser_valid && !ser_start: ignore the bit and pulse frame_err.
- SHIFT:
  - Each ser_valid cycle: shift in the bit, count+1.
  - When count reaches WIDTH: word complete, go to IDLE.
  - ser_start=1 in SHIFT: discard the partial word, pulse frame_err, and take the current bit as bit 0 of a new frame (count=1).
  - ser_valid=0: hold state and count; no timeout.
- Bit order:
  - LSB_FIRST=1: shift right, new bit enters at MSB ({bit, sr[W-1:1]}), so the first bit ends in bit 0.
  - LSB_FIRST=0: shift left, new bit enters at LSB.
- Completion latency: out_valid rises on the clock edge after the cycle in which the last bit is sampled. A back-to-back ser_start in the next cycle is accepted (zero dead cycles).
- Output buffer (one entry):
  - A completed word loads the buffer if the buffer is empty, or if it is being drained this cycle (out_valid && out_ready).
  - Otherwise the new word is dropped, the buffered word is kept unchanged, and overrun is set.
  - overrun clears only on rst.
- Handshake: out_valid stays high until accepted and never drops without out_ready. out_data is unchanged while out_valid && !out_ready.
- Arithmetic: bit counter width is $clog2(WIDTH+1); it never wraps past WIDTH.

Optional Feature:
Macro: SERIAL_DESERIALIZER_PARITY_EN.
- Defined:
  - After bit WIDTH, enter PARITY. The next ser_valid bit is the even-parity bit: parity bit = XOR of the data bits.
  - The word completes on that bit, and out_valid rises one edge later.
  - Adds output out_perr (1 bit), registered with out_data and held with it; 1 = parity mismatch. The word is still delivered.
  - ser_start in PARITY restarts the frame exactly as in SHIFT.
- Undefined: no PARITY state, no out_perr port; a frame is exactly WIDTH bits.

Decomposition:
- Shared package serial_pkg:
  - state enum (IDLE, SHIFT, PARITY);
  - localparam for the default WIDTH;
  - function for counter width.
- One natural sub-module: serial_out_buffer. It holds the one-entry valid/ready buffer and the overrun logic, and is reused by the future transmitter's input side.

Test Plan:
1. WIDTH=4, LSB_FIRST=1, rst, then bits 1,0,1,1 (start on the first) with out_ready=1 → out_data=4'b1101 and out_valid=1 exactly one edge after the fourth bit, held one cycle, no error flags.
2. ser_valid gaps (bits on cycles 0, 3, 4, 9) → same word as scenario 1; out_valid rises at the edge after cycle 9.
3. out_ready=0: send word 4'hA, then word 4'h5 → out_data stays 4'hA, overrun=1. Raise out_ready on the completion cycle of 4'h5 in a rerun → 4'h5 loaded and overrun stays 0.
4. After 2 bits, assert ser_start with bit 0, then send 3 more bits (0,1,1) → frame_err pulses one cycle and the word is 4'b1100 (the restart bit is bit 0).
5. Assert rst mid-frame (after 3 bits) and while out_valid=1 → all outputs 0 on the next edge, and the next full frame decodes correctly.
6. With PARITY_EN, data 4'b0111 + parity 1 → out_perr=0. Same data + parity 0 → out_perr=1, word still 4'b0111.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial link blocks (deserializer and future transmitter).
package serial_pkg;

  // Receive FSM states; PARITY is only reached when the parity bit is enabled.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Bit counter width: must represent 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_out_buffer.sv
// One-entry valid/ready word buffer with sticky overrun flag. A new word is accepted when the
// buffer is empty or being drained in the same cycle; otherwise it is dropped and overrun set.
module serial_out_buffer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_valid,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_overrun
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_overrun;
  logic             w_drain;
  logic             w_accept;

  // Accept when empty or when the held word leaves this cycle
  always_comb begin
    w_drain  = r_valid && i_rd_ready;
    w_accept = i_wr_valid && (!r_valid || w_drain);
  end

  // Buffer entry and sticky overrun; data only changes on accept so it is stable while stalled
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_data  <= i_wr_data;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end
      if (i_wr_valid && !w_accept) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_rd_valid = r_valid;
  assign o_rd_data  = r_data;
  assign o_overrun  = r_overrun;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: reassembles WIDTH-bit frames from a qualified bitstream and
// hands them out through a one-entry valid/ready buffer.
// Optional even-parity bit per frame: define SERIAL_DESERIALIZER_PARITY_EN (adds out_perr).
module serial_deserializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_valid,
  input  logic             ser_data,
  input  logic             ser_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             frame_err,
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  output logic             out_perr,
`endif
  output logic             overrun
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  localparam int unsigned BUF_W = WIDTH + 1;
`else
  localparam int unsigned BUF_W = WIDTH;
`endif

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_base;
  logic [WIDTH-1:0] w_sr_nxt;
  logic             r_frame_err;
  logic             w_shift;
  logic             w_restart;
  logic             w_ferr;
  logic             w_full;
  logic             w_done;
  logic [BUF_W-1:0] w_buf_in;
  logic [BUF_W-1:0] w_buf_out;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  logic             w_par_bit;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Control decode: classify each qualified bit as data shift, frame restart, parity or stray
  always_comb begin
    w_shift   = 1'b0;
    w_restart = 1'b0;
    w_ferr    = 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    w_par_bit = 1'b0;
`endif
    if (ser_valid) begin
      unique case (r_state)
        IDLE: begin
          if (ser_start) begin
            w_shift   = 1'b1;
            w_restart = 1'b1;
          end else begin
            w_ferr = 1'b1;
          end
        end
        SHIFT: begin
          w_shift = 1'b1;
          if (ser_start) begin
            w_restart = 1'b1;
            w_ferr    = 1'b1;
          end
        end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        PARITY: begin
          if (ser_start) begin
            w_shift   = 1'b1;
            w_restart = 1'b1;
            w_ferr    = 1'b1;
          end else begin
            w_par_bit = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Datapath next values; a restart shifts into a cleared register so the bit becomes bit 0
  always_comb begin
    w_cnt_nxt = w_restart ? CNT_W'(1) : r_cnt + CNT_W'(1);
    w_full    = w_shift && (w_cnt_nxt == CNT_W'(WIDTH));
    w_sr_base = w_restart ? '0 : r_sr;
    if (LSB_FIRST) begin
      w_sr_nxt = (w_sr_base >> 1) | (WIDTH'(ser_data) << (WIDTH - 1));
    end else begin
      w_sr_nxt = (w_sr_base << 1) | WIDTH'(ser_data);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_shift) begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
      w_state_nxt = w_full ? PARITY : SHIFT;
`else
      w_state_nxt = w_full ? IDLE : SHIFT;
`endif
    end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    else if (w_par_bit) begin
      w_state_nxt = IDLE;
    end
`endif
  end

  // Word completion: on the last data bit, or on the parity bit when parity is enabled
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  assign w_done   = w_par_bit;
  assign w_buf_in = {(^r_sr) ^ ser_data, r_sr};
`else
  assign w_done   = w_full;
  assign w_buf_in = w_sr_nxt;
`endif

  // Bit counter, shift register and registered frame-error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_sr        <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      if (w_shift) begin
        r_cnt <= w_full ? '0 : w_cnt_nxt;
        r_sr  <= w_sr_nxt;
      end
    end
  end

  serial_out_buffer #(
    .WIDTH(BUF_W)
  ) u_out_buffer (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_valid(w_done),
    .i_wr_data (w_buf_in),
    .o_rd_valid(out_valid),
    .i_rd_ready(out_ready),
    .o_rd_data (w_buf_out),
    .o_overrun (overrun)
  );

  assign out_data  = w_buf_out[WIDTH-1:0];
  assign frame_err = r_frame_err;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  assign out_perr  = w_buf_out[WIDTH];
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Bench for serial_deserializer: directed vector table, hand-written multi-cycle sequences and
// a randomized run against a frame-level reference model (two instances, both bit orders).
module tb_serial_deserializer;

  localparam int WA = 4;
  localparam int WB = 3;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ser_valid = 1'b0;
  logic ser_data = 1'b0;
  logic ser_start = 1'b0;
  logic out_ready = 1'b0;

  logic          a_valid, a_ferr, a_ovr;
  logic [WA-1:0] a_data;
  logic          b_valid, b_ferr, b_ovr;
  logic [WB-1:0] b_data;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  logic          a_perr, b_perr;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(WA), .LSB_FIRST(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .ser_valid(ser_valid), .ser_data(ser_data), .ser_start(ser_start),
    .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data), .frame_err(a_ferr),
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    .out_perr(a_perr),
`endif
    .overrun(a_ovr)
  );

  serial_deserializer #(.WIDTH(WB), .LSB_FIRST(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .ser_valid(ser_valid), .ser_data(ser_data), .ser_start(ser_start),
    .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data), .frame_err(b_ferr),
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    .out_perr(b_perr),
`endif
    .overrun(b_ovr)
  );

  // Directed vector: inputs {rst, valid, start, data, ready}; expectations after the edge
  typedef struct {
    logic [4:0] in;
    logic       ev;
    logic [3:0] ed;
    logic [1:0] fo;   // {frame_err, overrun}
  } vec_t;

  // Reference model state: frame as a list of received bits, plus the output buffer
  typedef struct {
    bit        in_frame;
    bit        await_par;
    int        n;
    bit [31:0] bits;
    bit        vld;
    bit [31:0] data;
    bit        perr;
    bit        ferr;
    bit        ovr;
  } mdl_t;

  function automatic vec_t mk(input logic [4:0] in, input logic ev, input logic [3:0] ed,
                              input logic [1:0] fo);
    vec_t v;
    v.in = in;
    v.ev = ev;
    v.ed = ed;
    v.fo = fo;
    return v;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t mi, input int w, input bit lsb,
                                    input logic [4:0] in);
    mdl_t      m = mi;
    bit        done = 1'b0;
    bit        perr = 1'b0;
    bit [31:0] word = '0;
    bit        drain;
    bit        r = in[4];
    bit        v = in[3];
    bit        s = in[2];
    bit        d = in[1];
    bit        rdy = in[0];
    if (r) begin
      m = '{default: 0};
      return m;
    end
    drain  = m.vld && rdy;
    m.ferr = 1'b0;
    if (v) begin
      if (s) begin
        m.ferr      = m.in_frame;
        m.in_frame  = 1'b1;
        m.await_par = 1'b0;
        m.bits      = '0;
        m.bits[0]   = d;
        m.n         = 1;
      end else if (!m.in_frame) begin
        m.ferr = 1'b1;
      end else if (m.await_par) begin
        done        = 1'b1;
        perr        = (^m.bits) ^ d;
        m.in_frame  = 1'b0;
        m.await_par = 1'b0;
      end else begin
        m.bits[m.n] = d;
        m.n++;
      end
      if (m.in_frame && !m.await_par && m.n == w) begin
        if (PAR) begin
          m.await_par = 1'b1;
        end else begin
          done       = 1'b1;
          m.in_frame = 1'b0;
        end
      end
    end
    if (done) begin
      for (int i = 0; i < w; i++) begin
        word[lsb ? i : (w - 1 - i)] = m.bits[i];
      end
      if (!m.vld || drain) begin
        m.vld  = 1'b1;
        m.data = word;
        m.perr = perr;
      end else begin
        m.ovr = 1'b1;
      end
    end else if (drain) begin
      m.vld = 1'b0;
    end
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [4:0] in);
    @(negedge clk);
    {rst, ser_valid, ser_start, ser_data, out_ready} = in;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  mdl_t ma, mb;

  initial begin
    // Reset state
    step(5'b10000);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_data", 32'(a_data), 32'd0);
    chk("rst_ferr", 32'(a_ferr), 32'd0);
    chk("rst_ovr", 32'(a_ovr), 32'd0);

`ifndef SERIAL_DESERIALIZER_PARITY_EN
    // Basic word 1101
    tbl.push_back(mk(5'b01111, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01001, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01011, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01011, 1'b1, 4'hD, 2'b00));
    tbl.push_back(mk(5'b00001, 1'b0, 4'h0, 2'b00));
    // Restart after two bits -> 1100
    tbl.push_back(mk(5'b01111, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01001, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01101, 1'b0, 4'h0, 2'b10));
    tbl.push_back(mk(5'b01001, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01011, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01011, 1'b1, 4'hC, 2'b00));
    tbl.push_back(mk(5'b00001, 1'b0, 4'h0, 2'b00));
    // Stray bit in idle
    tbl.push_back(mk(5'b01011, 1'b0, 4'h0, 2'b10));
    tbl.push_back(mk(5'b00001, 1'b0, 4'h0, 2'b00));
    // Stalled consumer: A kept, 5 dropped, overrun sticky
    tbl.push_back(mk(5'b01100, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01010, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01000, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01010, 1'b1, 4'hA, 2'b00));
    tbl.push_back(mk(5'b01110, 1'b1, 4'hA, 2'b00));
    tbl.push_back(mk(5'b01000, 1'b1, 4'hA, 2'b00));
    tbl.push_back(mk(5'b01010, 1'b1, 4'hA, 2'b00));
    tbl.push_back(mk(5'b01000, 1'b1, 4'hA, 2'b01));
    tbl.push_back(mk(5'b00001, 1'b0, 4'h0, 2'b01));
    tbl.push_back(mk(5'b10000, 1'b0, 4'h0, 2'b00));
    // Ready raised on the completion cycle of 5 -> 5 loaded, no overrun
    tbl.push_back(mk(5'b01100, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01010, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01000, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01010, 1'b1, 4'hA, 2'b00));
    tbl.push_back(mk(5'b01110, 1'b1, 4'hA, 2'b00));
    tbl.push_back(mk(5'b01000, 1'b1, 4'hA, 2'b00));
    tbl.push_back(mk(5'b01010, 1'b1, 4'hA, 2'b00));
    tbl.push_back(mk(5'b01001, 1'b1, 4'h5, 2'b00));
    tbl.push_back(mk(5'b00001, 1'b0, 4'h0, 2'b00));
    // Reset mid-frame, then a clean frame, then reset while holding a word
    tbl.push_back(mk(5'b01111, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01011, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01011, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b10000, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01110, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01000, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01010, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01010, 1'b1, 4'hD, 2'b00));
    tbl.push_back(mk(5'b10000, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01101, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01011, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01011, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01001, 1'b1, 4'h6, 2'b00));
    tbl.push_back(mk(5'b00001, 1'b0, 4'h0, 2'b00));
    // Back-to-back frames F then 8 with zero dead cycles
    tbl.push_back(mk(5'b01111, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01011, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01011, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01011, 1'b1, 4'hF, 2'b00));
    tbl.push_back(mk(5'b01101, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01001, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01001, 1'b0, 4'h0, 2'b00));
    tbl.push_back(mk(5'b01011, 1'b1, 4'h8, 2'b00));
    tbl.push_back(mk(5'b00001, 1'b0, 4'h0, 2'b00));

    foreach (tbl[i]) begin
      step(tbl[i].in);
      chk($sformatf("vec%0d_valid", i), 32'(a_valid), 32'(tbl[i].ev));
      if (tbl[i].ev || tbl[i].in[4]) begin
        chk($sformatf("vec%0d_data", i), 32'(a_data), 32'(tbl[i].ed));
      end
      chk($sformatf("vec%0d_ferr", i), 32'(a_ferr), 32'(tbl[i].fo[1]));
      chk($sformatf("vec%0d_ovr", i), 32'(a_ovr), 32'(tbl[i].fo[0]));
    end

    // ser_valid gaps: bits 1,0,1,1 on cycles 0,3,4,9; junk on start/data while invalid
    for (int c = 0; c < 10; c++) begin
      logic [4:0] in;
      in = {1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b1};
      if (c == 0) in = 5'b01111;
      if (c == 3) in = 5'b01001;
      if (c == 4) in = 5'b01011;
      if (c == 9) in = 5'b01011;
      step(in);
      chk($sformatf("gap_c%0d_valid", c), 32'(a_valid), (c == 9) ? 32'd1 : 32'd0);
      if (c == 9) chk("gap_data", 32'(a_data), 32'hD);
    end
    step(5'b00001);
`else
    // Data 0111 with correct parity 1, then again with wrong parity 0
    step(5'b01111);
    step(5'b01011);
    step(5'b01011);
    step(5'b01001);
    chk("par0_pending", 32'(a_valid), 32'd0);
    step(5'b01011);
    chk("par0_valid", 32'(a_valid), 32'd1);
    chk("par0_data", 32'(a_data), 32'h7);
    chk("par0_perr", 32'(a_perr), 32'd0);
    step(5'b01111);
    step(5'b01011);
    step(5'b01011);
    step(5'b01001);
    chk("par1_pending", 32'(a_valid), 32'd0);
    step(5'b01001);
    chk("par1_valid", 32'(a_valid), 32'd1);
    chk("par1_data", 32'(a_data), 32'h7);
    chk("par1_perr", 32'(a_perr), 32'd1);
    step(5'b00001);
`endif

    // Randomized run against the reference model, both instances
    step(5'b10000);
    ma = '{default: 0};
    mb = '{default: 0};
    for (int k = 0; k < 3000; k++) begin
      logic [4:0] in;
      in[4] = ($urandom_range(0, 199) == 0);
      in[3] = ($urandom_range(0, 3) != 0);
      in[2] = ($urandom_range(0, 5) == 0);
      in[1] = 1'($urandom);
      in[0] = ($urandom_range(0, 2) != 0);
      step(in);
      ma = mdl_next(ma, WA, 1'b1, in);
      mb = mdl_next(mb, WB, 1'b0, in);
      chk($sformatf("rnd%0d_a_valid", k), 32'(a_valid), 32'(ma.vld));
      chk($sformatf("rnd%0d_a_ferr", k), 32'(a_ferr), 32'(ma.ferr));
      chk($sformatf("rnd%0d_a_ovr", k), 32'(a_ovr), 32'(ma.ovr));
      chk($sformatf("rnd%0d_b_valid", k), 32'(b_valid), 32'(mb.vld));
      chk($sformatf("rnd%0d_b_ferr", k), 32'(b_ferr), 32'(mb.ferr));
      chk($sformatf("rnd%0d_b_ovr", k), 32'(b_ovr), 32'(mb.ovr));
      if (ma.vld) begin
        chk($sformatf("rnd%0d_a_data", k), 32'(a_data), ma.data);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        chk($sformatf("rnd%0d_a_perr", k), 32'(a_perr), 32'(ma.perr));
`endif
      end
      if (mb.vld) begin
        chk($sformatf("rnd%0d_b_data", k), 32'(b_data), mb.data);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        chk($sformatf("rnd%0d_b_perr", k), 32'(b_perr), 32'(mb.perr));
`endif
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
